rvv_core: RTL and testbench
===========================

# rvv_core

Single-issue, in-order RISC-V vector coprocessor that accepts one vector instruction at a time from a scalar core. It holds a 32×VLEN flop register file and executes a small integer subset (moves, add/sub/logic, optional multiply, unit-stride store). Store data streams out on a valid/grant port; completion, an illegal flag and the scalar result return to the scalar core's commit logic.

## Interface
- VLEN, 256: vector register length in bits.
- DataW, 64: width of `vrf_data_t`; one beat of data. Beats per register = VLEN/DataW = 4.
- Reset is `rst_ni`, asynchronous, active-low. Clock is `clk_i`.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- valid_i / ready_o  in/out  1  instruction handshake
- insn_i  in  32  instruction encoding
- insn_id_i  in  insn_id_t (3)  tag of the instruction
- vec_context_i  in  vec_context_t  {vl, vtype{vill, vma, vta, vsew[2:0], vlmul[2:0]}}
- flush_i  in  1  kill the uncommitted instruction
- insn_can_commit_i / insn_can_commit_id_i  in  1 / 3  commit permission for a tag
- done_o / done_insn_id_o  out  1 / 3  one-cycle completion pulse with its tag
- illegal_insn_o  out  1  qualifies done_o
- result_o  out  XLEN=64  scalar result, valid with done_o
- store_op_valid_o / store_op_o / store_op_gnt_i  out/out/in  1/DataW/1  store beat stream

## Operation
- Supported with vm=1, vstart=0, vlmul=000:
  - OPIVV (000) and OPIVI (011): vadd (000000), vsub (000010, vs2−vs1), vand (001001), vor (001010), vxor (001011).
  - vmv.v.v / vmv.v.i: funct6 010111, vs2=0. The simm5 immediate is sign-extended to SEW.
  - vmv.x.s: OPMVV 010, funct6 010000, vs1=0. result_o = element 0 of vs2, sign-extended to 64 bits.
  - vse8/16/32/64: opcode 0100111, width 000/101/110/111, mop=00, nf=0, lumop=0. EEW must equal SEW.
  - vmul.vv: OPMVV, funct6 100101. Available only with the macro; see Configuration.
- Illegal, reported with done_o=illegal_insn_o=1 and no side effects: any other encoding, vill=1, vm=0, vlmul≠000, or store EEW≠SEW.
- Element arithmetic is modulo 2^SEW, SIMD-packed within each beat.
- Element index = beat·(64/SEW) + lane. Bytes of elements with index ≥ vl are not written (tail undisturbed). vl>VLMAX is treated as VLMAX.
- A store emits ceil(vl·SEW/64) beats of vs3 raw data, starting at beat 0. vl=0 emits no beats; done_o is still reported.
- Each accepted, non-flushed instruction yields exactly one done pulse.

## Timing
- FSM states:
  - IDLE: ready_o=1. An accepted legal instruction goes to WAIT_COMMIT. An accepted illegal instruction goes to DONE.
  - WAIT_COMMIT: leaves when insn_can_commit_i=1 and the id matches the latched tag, going to EXEC or STORE. A commit presented in the accept cycle itself is honoured. flush_i here returns to IDLE with no done.
  - EXEC: one beat per cycle, 4 cycles, then DONE. vmv.x.s takes one cycle.
  - STORE: holds each beat until store_op_gnt_i; the last grant goes to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- After commit, flush_i is ignored.
- Best-case latency with commit in the accept cycle: ALU instruction, done 5 cycles after accept; illegal instruction, done the next cycle.
- store_op_o is stable while valid is high and not granted. The grant may be combinational in the same cycle.
- Reset values: ready_o=1, all other outputs 0, VRF zero. A reset mid-operation aborts the instruction and emits no done.

## Configuration
- RVV_MUL_EN defined: vmul.vv is decoded, giving the low SEW bits of the product, with EXEC timing.
- RVV_MUL_EN undefined: vmul.vv is reported illegal and no multiplier is built.

## Structure
- core_pkg holds insn_id_t, vec_context_t, vrf_data_t and xlen_t.
- rvv_pkg holds vtype_t, vlen_t, funct6/opcode/width constants and the FSM state enum.
- Sub-module rvv_vrf:
  - 32 registers by 4 beats.
  - Two combinational read ports (vs2, and vs1/vs3).
  - One write port with a byte-enable per beat.

## Test plan
- SEW32, vl=8: vmv.v.i v1,5; vadd.vv v2,v1,v1; vse32 v2 -> 4 beats, each 0x0000000a0000000a, then done with tag.
- SEW32, vl=3: vmv.v.i v3,-1 on a zeroed v3, then vse32 with vl=8 -> beat0 0xffffffffffffffff, beat1 0x00000000ffffffff, beats 2-3 all zero.
- SEW8: vsub.vv of 0x01 minus 0x02 -> every byte 0xff. vmv.x.s -> result_o = 0xffffffffffffffff.
- vill=1, or vm=0 -> done with illegal_insn_o=1 one cycle after accept; the VRF is unchanged.
- Commit withheld for 5 cycles, then flush_i -> no done, ready_o returns to 1, the VRF is unchanged.
- Store with grant held low for 3 cycles -> beat held stable, no duplicate beats. Without RVV_MUL_EN, vmul -> illegal.

Source files
------------

// File: rtl/core_pkg.sv
// Types shared with the scalar core: instruction tag, vector context, data beat, XLEN word.
package core_pkg;

  typedef logic [2:0]                  insn_id_t;
  typedef logic [rvv_pkg::DataW-1:0]   vrf_data_t;
  typedef logic [rvv_pkg::XLEN-1:0]    xlen_t;

  typedef struct packed {
    rvv_pkg::vlen_t  vl;
    rvv_pkg::vtype_t vtype;
  } vec_context_t;

endpackage

// File: rtl/rvv_pkg.sv
// Vector-unit constants, vtype/vl types, FSM and operation enums, and SIMD helpers.
package rvv_pkg;

  localparam int unsigned VLEN      = 256;
  localparam int unsigned DataW     = 64;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned NUM_BEATS = VLEN / DataW;

  typedef logic [7:0] vlen_t;

  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam logic [6:0] OPC_OPV   = 7'b1010111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;
  localparam logic [5:0] F6_VMV   = 6'b010111;
  localparam logic [5:0] F6_VMVXS = 6'b010000;
  localparam logic [5:0] F6_VMUL  = 6'b100101;

  typedef enum logic [2:0] {IDLE, WAIT_COMMIT, EXEC, STORE, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MV, OP_MVXS, OP_MUL, OP_STORE
  } op_e;

  // Byte-wise ripple add; the carry chain restarts at every element boundary.
  function automatic logic [DataW-1:0] simd_addsub(input logic [DataW-1:0] a,
                                                   input logic [DataW-1:0] b,
                                                   input logic [1:0] sew,
                                                   input logic sub);
    logic [DataW-1:0] r;
    logic [7:0]       bb;
    logic [8:0]       s;
    logic             c;
    int               mask;
    r    = '0;
    c    = 1'b0;
    mask = (1 << sew) - 1;
    for (int k = 0; k < DataW / 8; k++) begin
      if ((k & mask) == 0) c = sub;
      bb = sub ? ~b[8*k +: 8] : b[8*k +: 8];
      s  = {1'b0, a[8*k +: 8]} + {1'b0, bb} + {8'd0, c};
      r[8*k +: 8] = s[7:0];
      c  = s[8];
    end
    return r;
  endfunction

  function automatic logic [DataW-1:0] splat(input logic [DataW-1:0] v, input logic [1:0] sew);
    case (sew)
      2'd0:    return {8{v[7:0]}};
      2'd1:    return {4{v[15:0]}};
      2'd2:    return {2{v[31:0]}};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/rvv_vrf.sv
// Flop vector register file: 32 registers x 4 beats, two async read ports, byte-masked write.
module rvv_vrf
  import core_pkg::*;
  import rvv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] raddr_a,
  input  logic [4:0] raddr_b,
  input  logic [1:0] rbeat,
  output vrf_data_t  rdata_a,
  output vrf_data_t  rdata_b,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [1:0] wbeat,
  input  logic [7:0] wbe,
  input  vrf_data_t  wdata
);

  vrf_data_t mem_q [32][NUM_BEATS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++)
        for (int b = 0; b < NUM_BEATS; b++)
          mem_q[r][b] <= '0;
    end else if (we) begin
      for (int k = 0; k < 8; k++)
        if (wbe[k]) mem_q[waddr][wbeat][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata_a = mem_q[raddr_a][rbeat];
  assign rdata_b = mem_q[raddr_b][rbeat];

endmodule

// File: rtl/rvv_core.sv
// In-order vector coprocessor: decode, commit wait, 4-beat execute and store streaming.
// Optional build macro RVV_MUL_EN adds vmul.vv; without it vmul.vv decodes as illegal.
//
// state       | meaning
// IDLE        | ready for a new instruction
// WAIT_COMMIT | legal instruction latched, waiting for commit or flush
// EXEC        | one VRF beat per cycle (vmv.x.s: single cycle)
// STORE       | streaming vs3 beats, each held until granted
// DONE        | one-cycle completion pulse
module rvv_core
  import core_pkg::*;
  import rvv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [31:0]  insn_i,
  input  insn_id_t     insn_id_i,
  input  vec_context_t vec_context_i,
  input  logic         flush_i,
  input  logic         insn_can_commit_i,
  input  insn_id_t     insn_can_commit_id_i,
  output logic         done_o,
  output insn_id_t     done_insn_id_o,
  output logic         illegal_insn_o,
  output xlen_t        result_o,
  output logic         store_op_valid_o,
  output vrf_data_t    store_op_o,
  input  logic         store_op_gnt_i
);

  state_e state_q, state_d;
  op_e    op_q, dec_op;
  logic   dec_legal, dec_use_imm, use_imm_q, illegal_q, ctx_unused;
  logic [4:0] vd_q, vs1_q, vs2_q, simm_q;
  logic [1:0] sew_q, beat_q;
  logic [2:0] nbeats_q, dec_nbeats;
  vlen_t      vl_q, vlmax, vl_eff;
  logic [5:0] dec_bytes;
  insn_id_t   id_q;
  xlen_t      result_q, elem0;
  vrf_data_t  rdata_a, rdata_b, opb, alu_res;
  logic [7:0] wbe;
  logic [4:0] byte_idx;
  logic       we;

  wire [6:0] opcode = insn_i[6:0];
  wire [2:0] funct3 = insn_i[14:12];
  wire [5:0] funct6 = insn_i[31:26];
  wire [4:0] vs1_f  = insn_i[19:15];
  wire [4:0] vs2_f  = insn_i[24:20];
  wire [1:0] sew_in = vec_context_i.vtype.vsew[1:0];

  assign ctx_unused = vec_context_i.vtype.vma ^ vec_context_i.vtype.vta;

`ifdef RVV_MUL_EN
  function automatic vrf_data_t simd_mul(input vrf_data_t a, input vrf_data_t b, input logic [1:0] sew);
    vrf_data_t r;
    r = '0;
    case (sew)
      2'd0:    for (int i = 0; i < 8; i++) r[8*i +: 8]   = a[8*i +: 8] * b[8*i +: 8];
      2'd1:    for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] * b[16*i +: 16];
      2'd2:    for (int i = 0; i < 2; i++) r[32*i +: 32] = a[32*i +: 32] * b[32*i +: 32];
      default: r = a * b;
    endcase
    return r;
  endfunction
`endif

  function automatic state_e commit_target(input op_e op, input logic [2:0] nbeats);
    if (op != OP_STORE) return EXEC;
    return (nbeats == 3'd0) ? DONE : STORE;
  endfunction

  assign vlmax      = vlen_t'(32) >> sew_in;
  assign vl_eff     = (vec_context_i.vl > vlmax) ? vlmax : vec_context_i.vl;
  assign dec_bytes  = vl_eff[5:0] << sew_in;
  assign dec_nbeats = dec_bytes[5:3] + {2'b00, |dec_bytes[2:0]};

  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = OP_ADD;
    dec_use_imm = (funct3 == F3_OPIVI);
    if (opcode == OPC_OPV) begin
      if (funct3 == F3_OPIVV || funct3 == F3_OPIVI) begin
        dec_legal = 1'b1;
        case (funct6)
          F6_VADD: dec_op = OP_ADD;
          F6_VSUB: dec_op = OP_SUB;
          F6_VAND: dec_op = OP_AND;
          F6_VOR:  dec_op = OP_OR;
          F6_VXOR: dec_op = OP_XOR;
          F6_VMV: begin
            dec_op    = OP_MV;
            dec_legal = (vs2_f == 5'd0);
          end
          default: dec_legal = 1'b0;
        endcase
      end else if (funct3 == F3_OPMVV) begin
        if (funct6 == F6_VMVXS && vs1_f == 5'd0) begin
          dec_op    = OP_MVXS;
          dec_legal = 1'b1;
        end
`ifdef RVV_MUL_EN
        if (funct6 == F6_VMUL) begin
          dec_op    = OP_MUL;
          dec_legal = 1'b1;
        end
`endif
      end
    end else if (opcode == OPC_STORE) begin
      // nf/mew/mop zero, lumop zero; the width field's low bits equal the EEW code
      dec_op    = OP_STORE;
      dec_legal = (insn_i[31:26] == 6'd0) && (vs2_f == 5'd0) &&
                  (funct3 == 3'b000 || (funct3[2] && funct3[1:0] != 2'b00)) &&
                  (funct3[1:0] == sew_in);
    end
    dec_legal = dec_legal && !vec_context_i.vtype.vill && insn_i[25] &&
                (vec_context_i.vtype.vlmul == 3'b000) && !vec_context_i.vtype.vsew[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_i) begin
        if (!dec_legal) state_d = DONE;
        else if (insn_can_commit_i && insn_can_commit_id_i == insn_id_i)
          state_d = commit_target(dec_op, dec_nbeats);
        else state_d = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (insn_can_commit_i && insn_can_commit_id_i == id_q) state_d = commit_target(op_q, nbeats_q);
        else if (flush_i) state_d = IDLE;
      end
      EXEC:  if (op_q == OP_MVXS || beat_q == 2'd3) state_d = DONE;
      STORE: if (store_op_gnt_i && {1'b0, beat_q} == nbeats_q - 3'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= OP_ADD; use_imm_q <= 1'b0; illegal_q <= 1'b0;
      vd_q <= '0; vs1_q <= '0; vs2_q <= '0; simm_q <= '0;
      sew_q <= '0; vl_q <= '0; nbeats_q <= '0; id_q <= '0;
      result_q <= '0; beat_q <= '0;
    end else begin
      if (state_q == IDLE && valid_i) begin
        op_q      <= dec_op;
        use_imm_q <= dec_use_imm;
        illegal_q <= !dec_legal;
        vd_q      <= insn_i[11:7];
        vs1_q     <= vs1_f;
        vs2_q     <= vs2_f;
        simm_q    <= vs1_f;
        sew_q     <= sew_in;
        vl_q      <= vl_eff;
        nbeats_q  <= dec_nbeats;
        id_q      <= insn_id_i;
        result_q  <= '0;
      end
      if (state_q == EXEC && op_q == OP_MVXS) result_q <= elem0;
      if (state_q == EXEC || (state_q == STORE && store_op_gnt_i)) beat_q <= beat_q + 2'd1;
      else if (state_q != STORE) beat_q <= '0;
    end
  end

  assign opb = use_imm_q ? splat({{59{simm_q[4]}}, simm_q}, sew_q) : rdata_b;

  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = simd_addsub(rdata_a, opb, sew_q, 1'b0);
      OP_SUB:  alu_res = simd_addsub(rdata_a, opb, sew_q, 1'b1);
      OP_AND:  alu_res = rdata_a & opb;
      OP_OR:   alu_res = rdata_a | opb;
      OP_XOR:  alu_res = rdata_a ^ opb;
      OP_MV:   alu_res = opb;
`ifdef RVV_MUL_EN
      OP_MUL:  alu_res = simd_mul(rdata_a, opb, sew_q);
`endif
      default: alu_res = '0;
    endcase
    case (sew_q)
      2'd0:    elem0 = {{56{rdata_a[7]}}, rdata_a[7:0]};
      2'd1:    elem0 = {{48{rdata_a[15]}}, rdata_a[15:0]};
      2'd2:    elem0 = {{32{rdata_a[31]}}, rdata_a[31:0]};
      default: elem0 = rdata_a;
    endcase
  end

  // Byte k of the current beat belongs to element (beat*8 + k) >> sew; tail bytes stay untouched.
  always_comb begin
    wbe      = '0;
    byte_idx = '0;
    for (int k = 0; k < 8; k++) begin
      byte_idx = {beat_q, 3'(k)};
      wbe[k]   = {3'b000, (byte_idx >> sew_q)} < vl_q;
    end
  end

  assign we = (state_q == EXEC) && (op_q != OP_MVXS);

  rvv_vrf u_vrf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .raddr_a (vs2_q),
    .raddr_b ((op_q == OP_STORE) ? vd_q : vs1_q),
    .rbeat   (beat_q),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (we),
    .waddr   (vd_q),
    .wbeat   (beat_q),
    .wbe     (wbe),
    .wdata   (alu_res)
  );

  assign ready_o          = (state_q == IDLE);
  assign done_o           = (state_q == DONE);
  assign done_insn_id_o   = done_o ? id_q : '0;
  assign illegal_insn_o   = done_o & illegal_q;
  assign result_o         = done_o ? result_q : '0;
  assign store_op_valid_o = (state_q == STORE);
  assign store_op_o       = store_op_valid_o ? rdata_b : '0;

endmodule

// File: tb/tb_rvv_core.sv
// Directed self-checking bench for rvv_core with hand-computed expectations.
module tb_rvv_core;
  import core_pkg::*;
  import rvv_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [31:0]  insn_i = '0;
  insn_id_t     insn_id_i = '0;
  vec_context_t vec_context_i = '0;
  logic         flush_i = 1'b0;
  logic         insn_can_commit_i = 1'b0;
  insn_id_t     insn_can_commit_id_i = '0;
  logic         done_o;
  insn_id_t     done_insn_id_o;
  logic         illegal_insn_o;
  xlen_t        result_o;
  logic         store_op_valid_o;
  vrf_data_t    store_op_o;
  logic         store_op_gnt_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] beats[$];
  int          done_cyc;
  logic        done_ill;
  logic [63:0] done_res;
  logic [2:0]  done_id;

  localparam logic [2:0] SEW8  = 3'b000;
  localparam logic [2:0] SEW32 = 3'b010;
  localparam logic [63:0] A = 64'h0000000a0000000a;

  always #5 clk_i = ~clk_i;

  rvv_core dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .insn_i(insn_i), .insn_id_i(insn_id_i), .vec_context_i(vec_context_i),
    .flush_i(flush_i), .insn_can_commit_i(insn_can_commit_i),
    .insn_can_commit_id_i(insn_can_commit_id_i), .done_o(done_o),
    .done_insn_id_o(done_insn_id_o), .illegal_insn_o(illegal_insn_o),
    .result_o(result_o), .store_op_valid_o(store_op_valid_o),
    .store_op_o(store_op_o), .store_op_gnt_i(store_op_gnt_i)
  );

  function automatic logic [31:0] opv(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
    return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] vse(input logic [2:0] width, input logic [4:0] vs3);
    return {6'b000000, 1'b1, 5'd0, 5'd0, width, vs3, 7'b0100111};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] insn, input logic [2:0] id, input logic [7:0] vl,
                      input logic [2:0] sew, input logic vill, input logic commit);
    @(negedge clk_i);
    #1 chk("ready_before_send", ready_o, 1);
    valid_i = 1'b1; insn_i = insn; insn_id_i = id;
    vec_context_i.vl = vl;
    vec_context_i.vtype.vsew = sew;
    vec_context_i.vtype.vill = vill;
    vec_context_i.vtype.vlmul = 3'b000;
    insn_can_commit_i = commit; insn_can_commit_id_i = id;
    @(negedge clk_i);
    valid_i = 1'b0; insn_can_commit_i = 1'b0;
  endtask

  // Runs from the first negedge after accept until done; cycle 1 = first cycle after accept.
  task automatic run(input string tag, input int gnt_delay, input int commit_at, input logic [2:0] id);
    int w; logic held; logic [63:0] held_d; logic got;
    beats.delete();
    w = 0; held = 1'b0; held_d = '0; got = 1'b0; done_cyc = -1;
    for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
      insn_can_commit_i = (cyc == commit_at); insn_can_commit_id_i = id;
      #1;
      if (held) begin
        chk({tag, "_hold_valid"}, store_op_valid_o, 1);
        chk({tag, "_hold_data"}, store_op_o, held_d);
      end
      held = 1'b0;
      if (store_op_valid_o) begin
        if (w >= gnt_delay) begin
          store_op_gnt_i = 1'b1; beats.push_back(store_op_o); w = 0;
        end else begin
          store_op_gnt_i = 1'b0; w++; held = 1'b1; held_d = store_op_o;
        end
      end else store_op_gnt_i = 1'b0;
      if (done_o) begin
        got = 1'b1; done_cyc = cyc; done_ill = illegal_insn_o;
        done_res = result_o; done_id = done_insn_id_o;
      end
      @(negedge clk_i);
    end
    store_op_gnt_i = 1'b0; insn_can_commit_i = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      #1 chk({tag, "_single_pulse"}, done_o, 0);
    end
  endtask

  task automatic exec_chk(input string tag, input logic [31:0] insn, input logic [2:0] id,
                          input logic [7:0] vl, input logic [2:0] sew, input logic vill,
                          input int exp_cyc, input logic exp_ill);
    send(insn, id, vl, sew, vill, 1'b1);
    run(tag, 0, -1, id);
    chk({tag, "_latency"}, done_cyc, exp_cyc);
    chk({tag, "_illegal"}, done_ill, exp_ill);
    chk({tag, "_id"}, done_id, id);
  endtask

  task automatic store_chk(input string tag, input logic [4:0] vs3, input logic [2:0] width,
                           input logic [2:0] id, input logic [7:0] vl, input logic [2:0] sew,
                           input int gnt_delay, input int exp_n, input logic [63:0] e0,
                           input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    send(vse(width, vs3), id, vl, sew, 1'b0, 1'b1);
    run(tag, gnt_delay, -1, id);
    chk({tag, "_nbeats"}, beats.size(), exp_n);
    chk({tag, "_id"}, done_id, id);
    chk({tag, "_illegal"}, done_ill, 0);
    for (int i = 0; i < exp_n && i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), beats[i], e[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_illegal", illegal_insn_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_store_valid", store_op_valid_o, 0);
    chk("rst_store_data", store_op_o, 0);
    rst_ni = 1'b1;

    exec_chk("vmv_v_i", opv(F6_VMV, 1, 0, 5'd5, 3'b011, 1), 3'd1, 8, SEW32, 0, 5, 0);
    exec_chk("vadd_vv", opv(F6_VADD, 1, 1, 1, 3'b000, 2), 3'd2, 8, SEW32, 0, 5, 0);
    store_chk("vse32_v2", 2, 3'b110, 3'd3, 8, SEW32, 0, 4, A, A, A, A);
    chk("vse32_v2_latency", done_cyc, 5);

    exec_chk("vmv_tail", opv(F6_VMV, 1, 0, 5'h1f, 3'b011, 3), 3'd4, 3, SEW32, 0, 5, 0);
    store_chk("vse32_tail", 3, 3'b110, 3'd5, 8, SEW32, 0, 4,
              64'hffffffffffffffff, 64'h00000000ffffffff, 64'h0, 64'h0);

    exec_chk("vmv_v4", opv(F6_VMV, 1, 0, 5'd1, 3'b011, 4), 3'd6, 32, SEW8, 0, 5, 0);
    exec_chk("vmv_v5", opv(F6_VMV, 1, 0, 5'd2, 3'b011, 5), 3'd7, 32, SEW8, 0, 5, 0);
    exec_chk("vsub8", opv(F6_VSUB, 1, 4, 5, 3'b000, 6), 3'd0, 32, SEW8, 0, 5, 0);
    store_chk("vse8_v6", 6, 3'b000, 3'd1, 32, SEW8, 0, 4, '1, '1, '1, '1);
    exec_chk("vmvxs8", opv(F6_VMVXS, 1, 6, 0, 3'b010, 1), 3'd2, 32, SEW8, 0, 2, 0);
    chk("vmvxs8_result", done_res, 64'hffffffffffffffff);
    exec_chk("vmvxs32", opv(F6_VMVXS, 1, 2, 0, 3'b010, 1), 3'd3, 8, SEW32, 0, 2, 0);
    chk("vmvxs32_result", done_res, 64'h000000000000000a);

    exec_chk("ill_vill", opv(F6_VADD, 1, 2, 2, 3'b000, 2), 3'd4, 8, SEW32, 1, 1, 1);
    chk("ill_vill_result", done_res, 0);
    exec_chk("ill_vm0", opv(F6_VMV, 0, 0, 5'd7, 3'b011, 2), 3'd5, 8, SEW32, 0, 1, 1);
    send(vse(3'b000, 2), 3'd6, 8, SEW32, 0, 1);
    run("ill_eew", 0, -1, 3'd6);
    chk("ill_eew_latency", done_cyc, 1);
    chk("ill_eew_illegal", done_ill, 1);
    chk("ill_eew_nbeats", beats.size(), 0);
`ifdef RVV_MUL_EN
    exec_chk("vmul", opv(F6_VMUL, 1, 1, 1, 3'b010, 7), 3'd7, 8, SEW32, 0, 5, 0);
    store_chk("vse32_v7", 7, 3'b110, 3'd0, 8, SEW32, 0, 4,
              64'h0000001900000019, 64'h0000001900000019, 64'h0000001900000019, 64'h0000001900000019);
`else
    exec_chk("vmul", opv(F6_VMUL, 1, 1, 1, 3'b010, 7), 3'd7, 8, SEW32, 0, 1, 1);
    store_chk("vse32_v7", 7, 3'b110, 3'd0, 8, SEW32, 0, 4, 0, 0, 0, 0);
`endif
    store_chk("vse32_slow_gnt", 2, 3'b110, 3'd1, 8, SEW32, 3, 4, A, A, A, A);

    send(opv(F6_VMV, 1, 0, 5'd3, 3'b011, 2), 3'd2, 8, SEW32, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("flush_wait_done", done_o, 0);
      chk("flush_wait_ready", ready_o, 0);
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1 chk("flush_ready", ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("flush_no_done", done_o, 0);
      @(negedge clk_i);
    end
    store_chk("vse32_after_flush", 2, 3'b110, 3'd3, 8, SEW32, 0, 4, A, A, A, A);

    send(opv(F6_VAND, 1, 2, 5'd3, 3'b011, 8), 3'd4, 8, SEW32, 0, 0);
    run("late_commit", 0, 2, 3'd4);
    chk("late_commit_latency", done_cyc, 7);
    chk("late_commit_id", done_id, 3'd4);
    store_chk("vse32_v8", 8, 3'b110, 3'd5, 8, SEW32, 0, 4,
              64'h0000000200000002, 64'h0000000200000002, 64'h0000000200000002, 64'h0000000200000002);

    store_chk("vse32_vl0", 2, 3'b110, 3'd6, 0, SEW32, 0, 0, 0, 0, 0, 0);
    chk("vse32_vl0_latency", done_cyc, 1);

    send(vse(3'b110, 2), 3'd7, 8, SEW32, 0, 1);
    @(negedge clk_i);
    #1 chk("midrst_store_valid", store_op_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid_low", store_op_valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    chk("midrst_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("midrst_no_done", done_o, 0);
      @(negedge clk_i);
    end
    store_chk("vse32_after_rst", 2, 3'b110, 3'd0, 8, SEW32, 0, 4, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
